// File: rtl/reg_scoreboard_pkg.sv
// Shared register map, scoreboard geometry and helpers for the issue-stage hazard scoreboard.
package reg_scoreboard_pkg;

    typedef logic [7:0] reg_id_t;

    localparam reg_id_t RNIL   = 8'h00;
    localparam reg_id_t RIP    = 8'h01;
    localparam reg_id_t RAX    = 8'h10;
    localparam reg_id_t RCX    = 8'h11;
    localparam reg_id_t RDX    = 8'h12;
    localparam reg_id_t RBX    = 8'h13;
    localparam reg_id_t RSP    = 8'h14;
    localparam reg_id_t RBP    = 8'h15;
    localparam reg_id_t RFLAGS = 8'h20;
    localparam reg_id_t RH0    = 8'h21;

    localparam reg_id_t SB_FIRST = RAX;
    localparam reg_id_t SB_LAST  = RH0;
    localparam int SB_CNT   = int'(SB_LAST) - int'(SB_FIRST) + 1;
    localparam int SB_IDX_W = $clog2(SB_CNT);
    localparam int INFL_W   = $clog2(SB_CNT + 1);

    localparam int NUM_SRC_DEF = 3;
    localparam int NUM_DST_DEF = 2;
    localparam int NUM_WB_DEF  = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } sb_state_t;

    function automatic logic sb_tracked(reg_id_t id);
        return (id >= SB_FIRST) && (id <= SB_LAST);
    endfunction

    function automatic logic [SB_IDX_W-1:0] sb_idx(reg_id_t id);
        reg_id_t off;
        off = id - SB_FIRST;
        return off[SB_IDX_W-1:0];
    endfunction

    function automatic logic [INFL_W-1:0] sb_popcount(logic [SB_CNT-1:0] v);
        logic [INFL_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < SB_CNT; i++) begin
            cnt = cnt + INFL_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/reg_scoreboard_decode.sv
// Maps one register id onto the scoreboard: tracked flag, unmapped flag and one-hot busy-bit select.
module reg_sb_decode
    import reg_scoreboard_pkg::*;
(
    input  logic [7:0]        id,
    output logic              tracked,
    output logic              unmapped,
    output logic [SB_CNT-1:0] onehot
);

    always_comb begin
        tracked  = sb_tracked(id);
        unmapped = !tracked && (id != RNIL) && (id != RIP);
        onehot   = '0;
        if (tracked) begin
            onehot[sb_idx(id)] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// In-order issue hazard scoreboard: per-register pending-write bits, RAW/WAW stall, drain/flush sequencing.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int NUM_DST = NUM_DST_DEF,
    parameter int NUM_WB  = NUM_WB_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  issue_valid,
    input  logic [NUM_SRC*8-1:0]  issue_src,
    input  logic [NUM_DST*8-1:0]  issue_dst,
    output logic                  issue_ready,
    input  logic [NUM_WB-1:0]     wb_valid,
    input  logic [NUM_WB*8-1:0]   wb_reg,
    input  logic                  drain_req,
    input  logic                  flush,
    output logic                  drained,
    output logic [SB_CNT-1:0]     busy_vec,
    output logic [INFL_W-1:0]     inflight,
    output logic                  err
);

    localparam int NUM_P = NUM_SRC + NUM_DST + NUM_WB;
    localparam int DST_0 = NUM_SRC;
    localparam int WB_0  = NUM_SRC + NUM_DST;
    localparam logic [NUM_P-1:0] ISSUE_MASK = {{NUM_WB{1'b0}}, {(NUM_SRC + NUM_DST){1'b1}}};

    logic [7:0]        port_id [NUM_P];
    logic [SB_CNT-1:0] port_oh [NUM_P];
    logic [NUM_P-1:0]  port_trk;
    logic [NUM_P-1:0]  port_unm;

    logic [SB_CNT-1:0] busy_q, busy_d;
    logic [INFL_W-1:0] inflight_q, inflight_d;
    logic              err_q, err_d;
    sb_state_t         state_q, state_d;

    logic [SB_CNT-1:0] set_vec, clr_vec;
    logic              src_hit, dst_hit, fire, wb_err;

    // All src, dst and wb ids share one decoder bank: srcs first, then dsts, then wb ports.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) port_id[i]         = issue_src[i*8 +: 8];
        for (int i = 0; i < NUM_DST; i++) port_id[DST_0 + i] = issue_dst[i*8 +: 8];
        for (int i = 0; i < NUM_WB;  i++) port_id[WB_0 + i]  = wb_reg[i*8 +: 8];
    end

    for (genvar g = 0; g < NUM_P; g++) begin : g_dec
        reg_sb_decode u_dec (
            .id       (port_id[g]),
            .tracked  (port_trk[g]),
            .unmapped (port_unm[g]),
            .onehot   (port_oh[g])
        );
    end

    always_comb begin
        src_hit = 1'b0;
        dst_hit = 1'b0;
        set_vec = '0;
        clr_vec = '0;
        wb_err  = 1'b0;

        for (int i = 0; i < NUM_SRC; i++) begin
            if (port_trk[i] && |(port_oh[i] & busy_q)) src_hit = 1'b1;
        end
        for (int i = DST_0; i < WB_0; i++) begin
            if (port_trk[i] && |(port_oh[i] & busy_q)) dst_hit = 1'b1;
        end

        // Hazards use registered busy bits only; a writeback frees the register one cycle later.
        issue_ready = reset_n && (state_q == RUN) && !drain_req && !flush && !src_hit && !dst_hit;
        fire        = issue_valid && issue_ready;

        if (fire) begin
            for (int i = DST_0; i < WB_0; i++) begin
                if (port_trk[i]) set_vec = set_vec | port_oh[i];
            end
        end

        for (int i = WB_0; i < NUM_P; i++) begin
            if (wb_valid[i - WB_0] && port_trk[i]) begin
                clr_vec = clr_vec | port_oh[i];
                if (!(|(port_oh[i] & busy_q))) wb_err = 1'b1;
            end
        end

        busy_d     = flush ? '0 : ((busy_q & ~clr_vec) | set_vec);
        inflight_d = sb_popcount(busy_d);
        err_d      = err_q || wb_err || (fire && |(port_unm & ISSUE_MASK));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (drain_req) state_d = DRAIN;
            DRAIN: begin
                if (!drain_req)        state_d = RUN;
                else if (busy_d == '0) state_d = HALT;
            end
            HALT:    if (!drain_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_q     <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
            state_q    <= RUN;
        end else begin
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            state_q    <= state_d;
        end
    end

    assign busy_vec = busy_q;
    assign inflight = inflight_q;
    assign err      = err_q;
    assign drained  = (state_q == HALT);

endmodule
